eq_act_pipe: RTL and testbench
==============================

EQ_ACT_PIPE -- requirements
Module: eq_act_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 9: output sample width in bits; input sample width is 2*WIDTH.
REQ-002 SHALL have parameter CH, default 4: number of parallel channels per beat.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: input beat valid.
REQ-006 SHALL have port in_ready  output  1: block accepts the beat this cycle.
REQ-007 SHALL have port mode  input  2: activation select, sampled with the beat.
REQ-008 SHALL have port X  input  CH*2*WIDTH: signed samples; channel i occupies bits [(i+1)*2*WIDTH-1 : i*2*WIDTH].
REQ-009 SHALL have port out_valid  output  1: output beat valid.
REQ-010 SHALL have port out_ready  input  1: downstream accepts.
REQ-011 SHALL have port out  output  CH*WIDTH: signed results, channel i at bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-012 SHALL have port sat  output  CH: per-channel saturation flag, aligned with out.
REQ-013 SHALL have port sat_clr  input  1: synchronous clear of sat_count.
REQ-014 SHALL have port sat_count  output  16: running count of saturated channel results.

Function
REQ-015 SHALL evaluate every channel in at least 2*WIDTH+2 bits after sign extension; no intermediate overflow, including at X = most-negative and most-positive values.
REQ-016 SHALL implement mode 0: y = (|x+1| + |x-1|) >>> 1 (arithmetic shift, floor).
REQ-017 SHALL implement mode 1: y = (|x+1| - |x-1|) >>> 1 (hard-tanh, range -1..1).
REQ-018 SHALL implement mode 2: y = max(x, 0); mode 3: y = x (pass).
REQ-019 SHALL saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set sat[i] when clamping occurred; no bit-dropping truncation.
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers abs/sum terms and mode, stage 2 registers shift, clamp, out and sat.
REQ-021 SHALL transfer an input beat when in_valid && in_ready and an output beat when out_valid && out_ready.
REQ-022 SHALL drive in_ready = !out_valid || out_ready (global pipeline enable); all stages hold while disabled.
REQ-023 SHALL give latency 2 cycles, accepted beat to out_valid, without backpressure; throughput one beat per cycle.
REQ-024 SHALL hold out, sat and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL insert bubbles (stage valid low) when in_valid is low while enabled; no beat lost or duplicated.
REQ-026 SHALL apply mode per beat; a mode change between consecutive beats affects only later beats.
REQ-027 SHALL increase sat_count, on each output transfer, by the number of set sat bits, clamping at 65535.
REQ-028 SHALL give sat_clr priority over a same-cycle increment: sat_count becomes 0, that increment dropped.

Reset
REQ-029 SHALL, on rst high, immediately clear both stage valids, out_valid, out, sat and sat_count to 0, independent of clk.
REQ-030 SHALL discard in-flight beats on reset mid-operation; in_ready is 1 the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover (WIDTH=9, CH=4): mode 0, X={0,1,-1,2}, out_ready=1 -> out={1,1,1,2}, sat=0, out_valid 2 cycles after accept.
REQ-032 SHALL cover: mode 0, X={300,-300,131071,-131072} -> out={255,255,255,255}, sat=4'b1111, sat_count=4.
REQ-033 SHALL cover: mode 1, X={-5,0,5,1}, then mode 2 next beat X={-7,7,-256,256} -> {-1,0,1,1} then {0,7,0,255}, sat of 2nd beat only on channel 3.
REQ-034 SHALL cover: mode 3 stream of 6 beats with out_ready low 3 cycles mid-stream -> in_ready low while stalled, out stable, all 6 beats delivered in order, none duplicated.
REQ-035 SHALL cover: sat_count preset to 65534, beat with 4 saturations -> 65535; sat_clr coincident with a saturating transfer -> 0.
REQ-036 SHALL cover: rst asserted between clk edges with 2 beats in flight -> out_valid, sat_count 0 at once, no stale beat emitted after release.

Source files
------------

// File: rtl/eq_act_pipe.sv
`default_nettype none
// ============================================================================
// Module  : eq_act_pipe
// Brief   : CH-lane, two-stage activation pipeline (soft-abs / hard-tanh /
//           relu / pass) with output saturation, flags and saturation counter.
// Revision: 1.0  initial release
// ============================================================================
module eq_act_pipe #(
    parameter int WIDTH = 9,
    parameter int CH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [CH*2*WIDTH-1:0]   X,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*WIDTH-1:0]     out,
    output logic [CH-1:0]           sat,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
);

    localparam int c_XW = 2*WIDTH;
    localparam int c_IW = 2*WIDTH + 2;
    localparam logic signed [c_IW-1:0] c_MAX = c_IW'(2**(WIDTH-1) - 1);
    localparam logic signed [c_IW-1:0] c_MIN = -(c_IW'(2**(WIDTH-1)));

    logic                   w_en;
    logic [CH*c_IW-1:0]     w_term;
    logic [CH*c_IW-1:0]     r_term;
    logic [1:0]             r_mode;
    logic                   r_v1;
    logic [CH*WIDTH-1:0]    w_out;
    logic [CH-1:0]          w_sat;
    logic [16:0]            w_pop;
    logic [16:0]            w_sum;

    // One global enable: every stage advances together or holds together.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic signed [c_IW-1:0] w_x, w_xp, w_xm, w_ap, w_am, w_t1;
            logic signed [c_IW-1:0] w_t2, w_y;

            assign w_x  = {{2{X[(i+1)*c_XW-1]}}, X[i*c_XW +: c_XW]};
            assign w_xp = w_x + c_IW'(1);
            assign w_xm = w_x - c_IW'(1);
            assign w_ap = w_xp[c_IW-1] ? -w_xp : w_xp;
            assign w_am = w_xm[c_IW-1] ? -w_xm : w_xm;

            always_comb begin
                w_t1 = w_x;
                case (mode)
                    2'd0:    w_t1 = w_ap + w_am;
                    2'd1:    w_t1 = w_ap - w_am;
                    2'd2:    w_t1 = w_x[c_IW-1] ? '0 : w_x;
                    default: w_t1 = w_x;
                endcase
            end
            assign w_term[i*c_IW +: c_IW] = w_t1;

            // Modes 0/1 carry a doubled term from stage 1; halve it here.
            assign w_t2 = r_term[i*c_IW +: c_IW];
            assign w_y  = r_mode[1] ? w_t2 : (w_t2 >>> 1);
            assign w_sat[i] = (w_y > c_MAX) || (w_y < c_MIN);
            assign w_out[i*WIDTH +: WIDTH] = (w_y > c_MAX) ? c_MAX[WIDTH-1:0] :
                                             (w_y < c_MIN) ? c_MIN[WIDTH-1:0] :
                                                             w_y[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_mode    <= 2'd0;
            r_term    <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            sat       <= '0;
        end else if (w_en) begin
            r_v1      <= in_valid;
            out_valid <= r_v1;
            if (in_valid) begin
                r_mode <= mode;
                r_term <= w_term;
            end
            if (r_v1) begin
                out <= w_out;
                sat <= w_sat;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + 17'(sat[i]);
        end
    end
    assign w_sum = {1'b0, sat_count} + w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= 16'd0;
        end else if (sat_clr) begin
            sat_count <= 16'd0;
        end else if (out_valid && out_ready) begin
            sat_count <= (w_sum > 17'd65535) ? 16'hFFFF : w_sum[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_act_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_eq_act_pipe
// Brief   : Directed self-checking bench for eq_act_pipe (WIDTH=9, CH=4).
// Revision: 1.0  initial release
// ============================================================================
module tb_eq_act_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [71:0] X;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out;
    logic [3:0]  sat;
    logic        sat_clr;
    logic [15:0] sat_count;

    int passed = 0;
    int total  = 0;

    eq_act_pipe #(.WIDTH(9), .CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sat       (sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] px(input int a, input int b, input int c, input int d);
        return {18'(d), 18'(c), 18'(b), 18'(a)};
    endfunction

    function automatic logic [35:0] po(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int rcv;
        logic [35:0] prev;
        logic stalled_prev;

        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; X = '0; out_ready = 1'b1; sat_clr = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_sat", sat, 0);
        chk("reset_sat_count", sat_count, 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // mode 0, small values, latency
        mode = 2'd0; X = px(0, 1, -1, 2); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("m0_lat1_no_valid", out_valid, 0);
        step();
        chk("m0_lat2_valid", out_valid, 1);
        chk("m0_out", out, po(1, 1, 1, 2));
        chk("m0_sat", sat, 0);
        step();
        chk("m0_bubble", out_valid, 0);

        // mode 0, saturating extremes
        X = px(300, -300, 131071, -131072); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("m0_big_out", out, po(255, 255, 255, 255));
        chk("m0_big_sat", sat, 4'b1111);
        step();
        chk("m0_big_count", sat_count, 4);

        // mode 1 then mode 2, back to back
        mode = 2'd1; X = px(-5, 0, 5, 1); in_valid = 1'b1;
        step();
        mode = 2'd2; X = px(-7, 7, -256, 256);
        step();
        in_valid = 1'b0; mode = 2'd0;
        chk("m1_out", out, po(-1, 0, 1, 1));
        chk("m1_sat", sat, 0);
        step();
        chk("m2_valid", out_valid, 1);
        chk("m2_out", out, po(0, 7, 0, 255));
        chk("m2_sat", sat, 4'b1000);
        step();
        chk("m2_count", sat_count, 5);

        // mode 3 stream with a 3-cycle downstream stall
        mode = 2'd3; sent = 0; rcv = 0; prev = '0; stalled_prev = 1'b0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 6);
            X = px(sent*10 + 1, -(sent*10 + 1), 100 + sent, -100 - sent);
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (stalled_prev) chk("stall_out_stable", out, prev);
            end
            if (out_valid && out_ready) begin
                chk("stream_out", out, po(rcv*10 + 1, -(rcv*10 + 1), 100 + rcv, -100 - rcv));
                rcv++;
            end
            stalled_prev = out_valid && !out_ready;
            prev = out;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", rcv, 6);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stream_no_dup", out_valid, 0);
        end
        chk("stream_sat_count", sat_count, 5);

        // drive sat_count to 65534, then saturate the counter, then clear
        rst = 1'b1; #1; rst = 1'b0;
        mode = 2'd3; in_valid = 1'b1; X = px(300, 300, 300, 300);
        for (int k = 0; k < 16383; k++) step();
        X = px(300, 300, 0, 0);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("cnt_preset", sat_count, 65534);
        X = px(300, 300, 300, 300); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("cnt_clamp", sat_count, 65535);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_beat_valid", out_valid, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_priority", sat_count, 0);
        step();
        chk("clr_hold", sat_count, 0);

        // asynchronous reset with two beats in flight
        in_valid = 1'b1; X = px(300, 300, 300, 300);
        step(); step(); step();
        in_valid = 1'b0;
        chk("pre_rst_count", sat_count, 4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_count", sat_count, 0);
        chk("async_rst_out", out, 0);
        #1 rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("no_stale_beat", out_valid, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
